shift_serial: RTL and testbench
===============================

Name: shift_serial

Overview:
Multi-cycle, area-reduced counterpart of the single-cycle ALU shifter: performs SLL/SRL/SRA one bit position per clock instead of through a barrel network.
Sits beside the ALU for a multi-cycle datapath variant. Operands are accepted with a start pulse, busy is reported while shifting, and the result is returned with a one-cycle done pulse.
Opcode encoding is identical to the ALU shifter, so the control unit drives both the same way.

Parameters:
N, 32, datapath width in bits (power of two, >= 2)
SHW, $clog2(N), width of the effective shift amount; derived, not overridden

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_ni  input  1  reset, synchronous, active-low
start_i  input  1  request; sampled only when the unit is ready (IDLE or DONE)
a_i  input  N  operand to shift
b_i  input  N  shift amount; only b_i[SHW-1:0] is used
operacion_i  input  2  00 SLL, 01 SRL, 10 SRA, 11 invalid (result 0)
salida_o  output  N  result register; valid when done_o=1, held until next accepted start
busy_o  output  1  high while a shift is in progress (state SHIFT)
done_o  output  1  single-cycle pulse marking salida_o valid

Behaviour:
- Reset: rst_ni=0 sampled at a rising edge clears the following on that edge, regardless of state (including mid-shift):
  - state=IDLE, salida_o=0, busy_o=0, done_o=0, counter=0.
- States IDLE, SHIFT, DONE (encoding in package).
- busy_o is high iff state=SHIFT. done_o is high iff state=DONE. Both are registered, with no combinational path from inputs.
- Accept: in IDLE or DONE with start_i=1, the unit latches the following and ignores further input changes until completion:
  - a_i into salida_o, k=b_i[SHW-1:0] into the counter, operacion_i into an op register.
- Transitions on accept:
  - If k=0 or op=11, next state is DONE. For op=11, salida_o is loaded with 0 instead of a_i.
  - Otherwise next state is SHIFT.
- SHIFT: each edge applies one single-position step to salida_o and decrements the counter.
  - SLL: {r[N-2:0],0}. SRL: {0,r[N-1:1]}. SRA: {r[N-1],r[N-1:1]}.
  - When the counter reaches 0 on this edge, next state is DONE.
- DONE: lasts exactly one cycle. It goes to IDLE, or directly accepts a new start_i (back-to-back operation, no bubble).
- Latency: start sampled in cycle 0 gives done_o high in cycle k+1. For op=11 it is cycle 1. Maximum is N cycles (k=N-1).
- start_i during SHIFT is ignored: no queuing, no error.
- Shift amount masking: b_i >= N uses the low SHW bits only (b=32 with N=32 gives shift 0).
- salida_o never changes outside the accept edge, SHIFT edges, and reset.

Decomposition:
- Package shift_pkg:
  - opcode localparams OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10.
  - state encoding ST_IDLE, ST_SHIFT, ST_DONE.
- Sub-module shift_step: combinational, N-bit value plus 2-bit op in, value shifted by exactly one position out. Instantiated once in the top, keeping the FSM/counter logic separate from the data step.

Test Plan:
- SLL a=0x00000001, b=4, start in cycle 0:
  - busy_o high cycles 1-4.
  - done_o high cycle 5 only, with salida_o=0x00000010.
  - salida_o stays 0x00000010 afterwards.
- SRA a=0x80000000, b=31: done_o in cycle 32, salida_o=0xFFFFFFFF. SRL same operands: salida_o=0x00000001.
- Zero shift a=0xDEADBEEF with b=0 and b=0x20 (masked): busy_o never high, done_o in cycle 1, salida_o=0xDEADBEEF. With op=11 and any a, b: done_o in cycle 1, salida_o=0.
- SLL a=0x1, b=8 started, then start_i=1 in cycle 3 with a=0xFFFFFFFF, op=SRL: second request ignored, done_o cycle 9, salida_o=0x00000100.
- Back-to-back: start_i=1 in the DONE cycle with SRL a=0x100, b=8 is accepted, and the next done_o shows salida_o=0x00000001.
- Reset mid-shift: rst_ni=0 in cycle 3 of a b=10 shift gives state IDLE, salida_o=0, busy_o=0 after that edge, and no done_o pulse follows.

Source files
------------

// File: rtl/shift_pkg.sv
// shift_pkg: opcodes and FSM state encoding shared by the serial shifter.
package shift_pkg;
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
endpackage

// File: rtl/shift_step.sv
// shift_step: shifts a value by exactly one position according to op.
module shift_step
    import shift_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] value,
    input  logic [1:0]   op,
    output logic [N-1:0] result
);
    always_comb
        result = op == OP_SLL ? {value[N-2:0], 1'b0} :
                 op == OP_SRL ? {1'b0, value[N-1:1]} :
                 op == OP_SRA ? {value[N-1], value[N-1:1]} : '0;
endmodule

// File: rtl/shift_serial.sv
// shift_serial: multi-cycle SLL/SRL/SRA, one bit position per clock.
module shift_serial
    import shift_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [1:0]   operacion_i,
    output logic [N-1:0] salida_o,
    output logic         busy_o,
    output logic         done_o
);
    localparam int SHW = $clog2(N);
    state_t         state, nxt;
    logic [SHW-1:0] cnt, k;
    logic [1:0]     op;
    logic [N-1:0]   stepped;
    logic           accept, trivial;
    logic           unused_b;
    assign unused_b = ^b_i[N-1:SHW];
    shift_step #(.N(N)) u_step (.value(salida_o), .op(op), .result(stepped));
    always_comb begin
        k       = b_i[SHW-1:0];
        accept  = start_i && state != ST_SHIFT;
        trivial = k == '0 || operacion_i == 2'b11;
        nxt     = state == ST_SHIFT ? (cnt == SHW'(1) ? ST_DONE : ST_SHIFT) :
                  accept ? (trivial ? ST_DONE : ST_SHIFT) : ST_IDLE;
    end
    // busy/done come from the next state so both are plain flops.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= ST_IDLE;
            salida_o <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            cnt      <= '0;
            op       <= OP_SLL;
        end else begin
            state  <= nxt;
            busy_o <= nxt == ST_SHIFT;
            done_o <= nxt == ST_DONE;
            if (state == ST_SHIFT) begin
                salida_o <= stepped;
                cnt      <= cnt - SHW'(1);
            end else if (accept) begin
                salida_o <= operacion_i == 2'b11 ? '0 : a_i;
                cnt      <= k;
                op       <= operacion_i;
            end
        end
    end
endmodule

// File: tb/tb_shift_serial.sv
// tb_shift_serial: directed and random checks against an arithmetic shift model.
module tb_shift_serial;
    localparam int N = 32;
    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         start_i = 1'b0;
    logic [N-1:0] a_i = '0;
    logic [N-1:0] b_i = '0;
    logic [1:0]   operacion_i = 2'b00;
    logic [N-1:0] salida_o;
    logic         busy_o, done_o;
    int           checks = 0;
    int           errors = 0;
    logic [N-1:0] exp_r;
    int           lat;

    always #5 clk = ~clk;

    shift_serial #(.N(N)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .a_i(a_i), .b_i(b_i),
        .operacion_i(operacion_i), .salida_o(salida_o), .busy_o(busy_o), .done_o(done_o)
    );

    function automatic logic [N-1:0] ref_shift(logic [N-1:0] a, logic [N-1:0] b, logic [1:0] op);
        int k = int'(b % N);
        case (op)
            2'd0:    return a << k;
            2'd1:    return a >> k;
            2'd2:    return $unsigned($signed(a) >>> k);
            default: return '0;
        endcase
    endfunction

    function automatic int ref_lat(logic [N-1:0] b, logic [1:0] op);
        int k = int'(b % N);
        return (op == 2'd3 || k == 0) ? 1 : k + 1;
    endfunction

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] op);
        a_i = a;
        b_i = b;
        operacion_i = op;
        start_i = 1'b1;
        exp_r = ref_shift(a, b, op);
        lat = ref_lat(b, op);
    endtask

    task automatic watch(input int inject);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c == 1) start_i = 1'b0;
            if (inject > 0 && c == inject) begin
                start_i = 1'b1;
                a_i = '1;
                b_i = $urandom;
                operacion_i = 2'b01;
            end else if (inject > 0 && c == inject + 1) start_i = 1'b0;
            chk("busy", 32'(busy_o), 32'(c < lat));
            chk("done", 32'(done_o), 32'(c == lat));
            if (c == lat) chk("result", salida_o, exp_r);
        end
    endtask

    task automatic tail();
        @(negedge clk);
        chk("done_low", 32'(done_o), 32'd0);
        chk("busy_low", 32'(busy_o), 32'd0);
        chk("held", salida_o, exp_r);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_salida", salida_o, '0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk);
        start_op(32'h1, 32'd4, 2'd0);               watch(0); tail(); tail();
        start_op(32'h8000_0000, 32'd31, 2'd2);      watch(0); tail();
        start_op(32'h8000_0000, 32'd31, 2'd1);      watch(0); tail();
        start_op(32'hDEAD_BEEF, 32'd0, 2'd1);       watch(0); tail();
        start_op(32'hDEAD_BEEF, 32'h20, 2'd0);      watch(0); tail();
        start_op($urandom, $urandom, 2'd3);         watch(0); tail();
        start_op(32'h1, 32'd8, 2'd0);               watch(3); tail();
        start_op(32'h1, 32'd8, 2'd0);               watch(0);
        start_op(32'h100, 32'd8, 2'd1);             watch(0); tail();
        start_op(32'h1, 32'd10, 2'd0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) start_i = 1'b0;
        end
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        chk("midrst_salida", salida_o, '0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_done", 32'(done_o), 32'd0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("no_done_after_rst", 32'(done_o), 32'd0);
        end
        for (int i = 0; i < 30; i++) begin
            start_op($urandom, 32'($urandom_range(0, 63)), 2'($urandom_range(0, 3)));
            watch(0);
            if ($urandom_range(0, 1) == 1) tail();
        end
        tail();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
